// File: rtl/decrypt_stream_unit_pkg.sv
// Shared definitions for the decrypt stream unit.
//   state_e        : control FSM states
//   DEFAULT_POLY   : default Galois LFSR feedback mask (16-bit chunks)
//   DEFAULT_KEY    : key value after reset
//   fold_seed()    : XOR-folds a key into one chunk-wide LFSR seed
package decrypt_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StDecrypt,
      StOutput
   } state_e;

   localparam logic [15:0] DEFAULT_POLY = 16'hB400;
   localparam logic [63:0] DEFAULT_KEY  = 64'h9c18a4b3d408eeb7;

   // The fold is written against fixed maximum widths so that one function serves every
   // parameterisation. Supported: KEY_W <= 256, DATAW <= 64, KEY_W/DATAW <= 64.
   localparam int unsigned FOLD_MAX_KEY_W  = 256;
   localparam int unsigned FOLD_MAX_DATAW  = 64;
   localparam int unsigned FOLD_MAX_CHUNKS = 64;

   // XOR of all dataw-wide chunks of key; an all-zero result would lock the LFSR,
   // so it is replaced by all-ones.
   function automatic logic [FOLD_MAX_DATAW-1:0] fold_seed(
      input logic [FOLD_MAX_KEY_W-1:0] key,
      input int unsigned               key_w,
      input int unsigned               dataw
   );
      logic [FOLD_MAX_DATAW-1:0] mask;
      logic [FOLD_MAX_DATAW-1:0] acc;
      mask = {FOLD_MAX_DATAW{1'b1}} >> (FOLD_MAX_DATAW - dataw);
      acc  = '0;
      for (int unsigned i = 0; i < FOLD_MAX_CHUNKS; i++) begin
         if (i < key_w / dataw) begin
            acc = acc ^ (FOLD_MAX_DATAW'(key >> (i * dataw)) & mask);
         end
      end
      if (acc == '0) begin
         acc = mask;
      end
      return acc;
   endfunction

endpackage

// File: rtl/decrypt_stream_unit_if.sv
// Word stream bundle for the decrypt stream unit.
//   in_data/in_valid/in_ready    : ciphertext word handshake (producer -> unit)
//   out_data/out_valid/out_ready : plaintext word handshake (unit -> consumer)
// master: the side that feeds ciphertext and consumes plaintext.
// slave : the decrypt unit itself.
interface decrypt_stream_unit_if #(
   parameter int unsigned IN_W = 32
);
   logic [IN_W-1:0] in_data;
   logic            in_valid;
   logic            in_ready;
   logic [IN_W-1:0] out_data;
   logic            out_valid;
   logic            out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/decrypt_stream_unit_lfsr.sv
// Chunk-wide Galois LFSR holding the keystream state.
//   clk   : rising-edge clock
//   load  : replace the state with seed (wins over step)
//   step  : advance one step: lsb = s[0]; s >>= 1; if lsb, s ^= POLY
//   seed  : value used by load
//   state : current LFSR state
// No reset port: the owner drives load with the reset seed while its reset is asserted.
module keystream_lfsr
   import decrypt_pkg::*;
#(
   parameter int unsigned      DATAW = 16,
   parameter logic [DATAW-1:0] POLY  = DATAW'(DEFAULT_POLY)
) (
   input  logic             clk,
   input  logic             load,
   input  logic             step,
   input  logic [DATAW-1:0] seed,
   output logic [DATAW-1:0] state
);

   logic [DATAW-1:0] state_q;
   logic [DATAW-1:0] state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = seed;
      end else if (step) begin
         state_d = (state_q >> 1) ^ (state_q[0] ? POLY : '0);
      end
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/decrypt_stream_unit.sv
// Stream decryptor: XORs each DATAW chunk of a ciphertext word with an LFSR keystream and
// the matching key chunk, one chunk per clock, then presents the plaintext word.
//   clk, reset : clock; synchronous active-high reset
//   key_in     : new key value, taken when key_load is high in IDLE
//   key_load   : one-cycle key load request
//   ks_mode    : 0 = keystream continues across words, 1 = reseed from key per word
//   bus        : word stream handshakes (slave side)
//   key_err    : sticky, key_load seen while a word was in flight
//   word_cnt   : words delivered, wraps at 16 bits
module decrypt_stream_unit
   import decrypt_pkg::*;
#(
   parameter int unsigned      IN_W        = 32,
   parameter int unsigned      KEY_W       = 64,
   parameter int unsigned      DATAW       = 16,
   parameter logic [DATAW-1:0] POLY        = DATAW'(DEFAULT_POLY),
   parameter logic [KEY_W-1:0] KEY_DEFAULT = KEY_W'(DEFAULT_KEY)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [KEY_W-1:0]     key_in,
   input  logic                 key_load,
   input  logic                 ks_mode,
   decrypt_stream_unit_if.slave bus,
   output logic                 key_err,
   output logic [15:0]          word_cnt
);

   localparam int unsigned NCH    = IN_W / DATAW;
   localparam int unsigned NKC    = KEY_W / DATAW;
   localparam int unsigned IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned KIDX_W = (NKC > 1) ? $clog2(NKC) : 1;

   function automatic logic [DATAW-1:0] seed_of(input logic [KEY_W-1:0] k);
      return DATAW'(fold_seed(FOLD_MAX_KEY_W'(k), KEY_W, DATAW));
   endfunction

   state_e              state_q;
   state_e              state_d;
   logic [KEY_W-1:0]    key_q;
   logic [IN_W-1:0]     data_q;
   logic [IN_W-1:0]     out_data_q;
   logic [IDX_W-1:0]    idx_q;
   logic                key_err_q;
   logic [15:0]         word_cnt_q;

   logic                in_ready;
   logic                out_valid;
   logic                handshake;
   logic                last_chunk;
   logic                lfsr_load;
   logic                lfsr_step;
   logic [DATAW-1:0]    lfsr_seed;
   logic [DATAW-1:0]    lfsr_state;
   logic [KIDX_W-1:0]   kidx;
   logic [DATAW-1:0]    key_chunk;
   logic [IN_W-1:0]     plain_word;

   assign handshake  = bus.in_valid && in_ready;
   assign last_chunk = (idx_q == IDX_W'(NCH - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (handshake)     state_d = StDecrypt;
         StDecrypt: if (last_chunk)    state_d = StOutput;
         StOutput:  if (bus.out_ready) state_d = StIdle;
         default:                      state_d = StIdle;
      endcase
   end

   // ---------------- FSM: outputs and keystream control ----------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      lfsr_seed = seed_of(key_q);
      unique case (state_q)
         StIdle:    in_ready  = !key_load && !reset;
         StDecrypt: lfsr_step = 1'b1;
         StOutput:  out_valid = 1'b1;
         default:   ;
      endcase
      // Load priority: reset seed, then a key load, then a per-word reseed.
      if (reset) begin
         lfsr_load = 1'b1;
         lfsr_seed = seed_of(KEY_DEFAULT);
      end else if (state_q == StIdle && key_load) begin
         lfsr_load = 1'b1;
         lfsr_seed = seed_of(key_in);
      end else if (in_ready && bus.in_valid && ks_mode) begin
         lfsr_load = 1'b1;
      end
   end

   keystream_lfsr #(
      .DATAW (DATAW),
      .POLY  (POLY)
   ) u_lfsr (
      .clk   (clk),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .seed  (lfsr_seed),
      .state (lfsr_state)
   );

   // Current word with chunk idx_q replaced by its plaintext.
   always_comb begin
      kidx       = KIDX_W'(32'(idx_q) % NKC);
      key_chunk  = key_q[kidx*DATAW +: DATAW];
      plain_word = data_q;
      plain_word[idx_q*DATAW +: DATAW] = data_q[idx_q*DATAW +: DATAW] ^ lfsr_state ^ key_chunk;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         key_q      <= KEY_DEFAULT;
         data_q     <= '0;
         out_data_q <= '0;
         idx_q      <= '0;
         key_err_q  <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         if (key_load) begin
            if (state_q == StIdle) begin
               key_q <= key_in;
            end else begin
               key_err_q <= 1'b1;
            end
         end
         if (handshake) begin
            data_q <= bus.in_data;
            idx_q  <= '0;
         end
         if (state_q == StDecrypt) begin
            data_q <= plain_word;
            idx_q  <= idx_q + IDX_W'(1);
            // out_data keeps the previous word until the new one is complete.
            if (last_chunk) begin
               out_data_q <= plain_word;
            end
         end
         if (out_valid && bus.out_ready) begin
            word_cnt_q <= word_cnt_q + 16'd1;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data_q;
   assign key_err       = key_err_q;
   assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_decrypt_stream_unit.sv
// Scoreboard bench for decrypt_stream_unit: the driver pushes the hand-computed plaintext
// of each word it sends; a monitor pops and compares on every out_valid && out_ready.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_decrypt_stream_unit;
   import decrypt_pkg::*;

   localparam int unsigned IN_W  = 32;
   localparam int unsigned KEY_W = 64;
   localparam int unsigned DATAW = 16;
   localparam int unsigned NCH   = IN_W / DATAW;

   // Hand-computed plaintexts of an all-zero ciphertext word.
   localparam logic [31:0] P_K0_W1   = 32'hCBFFFFFF; // key 0, seed 0xFFFF
   localparam logic [31:0] P_K0_W2   = 32'hDCFFD1FF; // key 0, continuing keystream
   localparam logic [31:0] P_K0_W3   = 32'hD93FDA7F; // key 0, third continuing word
   localparam logic [31:0] P_KDEF_W1 = 32'hD502ECA3; // default key, seed 0x0214

   logic              clk      = 1'b0;
   logic              reset    = 1'b1;
   logic [KEY_W-1:0]  key_in   = '0;
   logic              key_load = 1'b0;
   logic              ks_mode  = 1'b0;
   logic              key_err;
   logic [15:0]       word_cnt;

   decrypt_stream_unit_if #(.IN_W(IN_W)) bus ();

   decrypt_stream_unit #(
      .IN_W        (IN_W),
      .KEY_W       (KEY_W),
      .DATAW       (DATAW),
      .POLY        (16'hB400),
      .KEY_DEFAULT (64'h9c18a4b3d408eeb7)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .key_in   (key_in),
      .key_load (key_load),
      .ks_mode  (ks_mode),
      .bus      (bus.slave),
      .key_err  (key_err),
      .word_cnt (word_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted output word is compared against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got 0x%0h, want no word", bus.out_data);
            end else begin
               check("out_data", bus.out_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1;
      exp_q.delete();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic load_key(input logic [KEY_W-1:0] k);
      tick();
      key_in   = k;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
   endtask

   // Presents a word and returns just after its handshake edge.
   task automatic start_word(input logic [31:0] data, input logic mode,
                             input logic [31:0] exp, input bit push);
      bit done = 1'b0;
      tick();
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      ks_mode      = mode;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL handshake: got in_ready=0 for 20 cycles, want 1");
      end else if (push) begin
         exp_q.push_back(exp);
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Counts edges from the handshake edge to the one that raised out_valid; -1 on timeout.
   task automatic wait_valid(output int edges);
      bit seen = 1'b0;
      edges = -1;
      for (int n = 1; n <= 20 && !seen; n++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen  = 1'b1;
            edges = n - 1;
         end
      end
   endtask

   task automatic send(input logic [31:0] data, input logic mode, input logic [31:0] exp);
      int edges;
      start_word(data, mode, exp, 1'b1);
      wait_valid(edges);
      check("latency_edges", 32'(edges), 32'(NCH));
      @(negedge clk);
      check("out_valid_drop", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      int edges;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Idle outputs after reset.
      @(negedge clk);
      check("idle_in_ready",  32'(bus.in_ready),  32'd1);
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_out_data",  bus.out_data,       32'd0);
      check("idle_word_cnt",  32'(word_cnt),      32'd0);
      check("idle_key_err",   32'(key_err),       32'd0);

      // Key load beats a simultaneous in_valid; then a reseeded word under key 0.
      tick();
      key_in       = '0;
      key_load     = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h5A5A5A5A;
      @(negedge clk);
      check("keyload_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      key_load     = 1'b0;
      bus.in_valid = 1'b0;
      send(32'h0, 1'b1, P_K0_W1);
      check("cnt_after_1", 32'(word_cnt), 32'd1);
      @(negedge clk);
      check("out_data_retained", bus.out_data, P_K0_W1);

      // Continuous keystream across words, then a reseed restarts it.
      do_reset();
      load_key('0);
      send(32'h0, 1'b0, P_K0_W1);
      send(32'h0, 1'b0, P_K0_W2);
      check("cnt_after_2", 32'(word_cnt), 32'd2);
      send(32'h0, 1'b0, P_K0_W3);
      send(32'h0, 1'b1, P_K0_W1);
      check("cnt_after_4", 32'(word_cnt), 32'd4);

      // Backpressure with a key load attempted mid-word.
      tick();
      bus.out_ready = 1'b0;
      start_word(32'h0, 1'b1, P_K0_W1, 1'b1);
      key_in   = 64'h1;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      wait_valid(edges);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
         check("hold_out_data",  bus.out_data,       P_K0_W1);
         check("hold_in_ready",  32'(bus.in_ready),  32'd0);
      end
      check("key_err_set", 32'(key_err), 32'd1);
      tick();
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("hold_released", 32'(bus.out_valid), 32'd0);
      send(32'h0, 1'b1, P_K0_W1);
      check("key_err_sticky", 32'(key_err), 32'd1);

      // Reset mid-decrypt discards the word and restores the default key.
      start_word(32'h0, 1'b1, 32'h0, 1'b0);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("reset_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("discarded_out_valid", 32'(bus.out_valid), 32'd0);
      end
      check("reset_key_err",  32'(key_err),  32'd0);
      check("reset_word_cnt", 32'(word_cnt), 32'd0);
      check("reset_out_data", bus.out_data,  32'd0);
      send(32'h0, 1'b1, P_KDEF_W1);

      // word_cnt wrap: counter preset near the top, then two more deliveries.
      tick();
      dut.word_cnt_q = 16'hFFFE;
      send(32'h0, 1'b1, P_KDEF_W1);
      check("cnt_ffff", 32'(word_cnt), 32'h0000FFFF);
      send(32'h0, 1'b1, P_KDEF_W1);
      check("cnt_wrap", 32'(word_cnt), 32'h00000000);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decrypt_stream_unit.md
DECRYPT_STREAM_UNIT -- requirements
Module: decrypt_stream_unit

Interface
REQ-001 Parameter IN_W, default 32, ciphertext/plaintext word width; a multiple of DATAW.
REQ-002 Parameter KEY_W, default 64, key width; a multiple of DATAW.
REQ-003 Parameter DATAW, default 16, chunk width processed per clock.
REQ-004 Parameter POLY, default 16'hB400, Galois LFSR feedback mask of width DATAW.
REQ-005 Parameter KEY_DEFAULT, default 64'h9c18a4b3d408eeb7, key value after reset.
REQ-006 Ports, clock and reset first:
  clk  in  1  single clock; all state updates on its rising edge.
  reset  in  1  synchronous, active-high reset.
  key_in  in  KEY_W  new key value.
  key_load  in  1  one-cycle request to load key_in.
  ks_mode  in  1  0 = continuous keystream across words, 1 = reseed per word.
  in_data  in  IN_W  ciphertext word.
  in_valid  in  1  in_data is valid.
  in_ready  out  1  word accepted when in_valid && in_ready.
  out_data  out  IN_W  plaintext word.
  out_valid  out  1  out_data is valid; held until out_ready.
  out_ready  in  1  consumer accepts out_data.
  key_err  out  1  sticky: key_load arrived while busy.
  word_cnt  out  16  count of words delivered.

Function
REQ-007 NCH = IN_W/DATAW chunks per word and NKC = KEY_W/DATAW key chunks; chunk 0 is the least-significant chunk.
REQ-008 Seed = XOR of all NKC key chunks; a zero seed is replaced by all-ones.
REQ-009 LFSR step: lsb = s[0]; s = s >> 1; if lsb, s ^= POLY.
REQ-010 States: IDLE, DECRYPT, OUTPUT.
REQ-011 in_ready = (state == IDLE) && !key_load && !reset.
REQ-012 IDLE -> DECRYPT on an in_valid && in_ready handshake:
  - latch in_data;
  - clear chunk index;
  - if ks_mode = 1, load the LFSR with the seed of the current key.
REQ-013 DECRYPT, one chunk per cycle, for chunk i:
  - plain[i] = cipher[i] ^ lfsr ^ key_chunk[i mod NKC];
  - advance the LFSR one step;
  - move to OUTPUT after chunk NCH-1.
REQ-014 out_valid rises on the edge NCH cycles after the handshake edge, i.e. latency NCH+1 cycles from handshake to observable out_valid.
REQ-015 OUTPUT holds out_data and out_valid stable while out_ready = 0.
REQ-016 On out_valid && out_ready:
  - return to IDLE;
  - drop out_valid;
  - word_cnt += 1, wrapping from 0xFFFF to 0x0000.
REQ-017 At most one word is in flight; there is no input buffering.
REQ-018 key_load in IDLE:
  - key register <= key_in;
  - LFSR <= seed(key_in);
  - takes priority over a simultaneous in_valid, which is not accepted that cycle.
REQ-019 key_load in DECRYPT or OUTPUT is ignored and sets key_err; key_err clears only on reset.
REQ-020 ks_mode is sampled only at the handshake; in mode 0 the LFSR state carries across words.
REQ-021 out_data retains the last delivered word after return to IDLE.

Reset
REQ-022 Reset takes effect in any state, including mid-DECRYPT or OUTPUT, and discards the in-flight word.
REQ-023 Values after reset:
  - state IDLE; out_valid 0; out_data 0;
  - key register KEY_DEFAULT; LFSR seed(KEY_DEFAULT);
  - key_err 0; word_cnt 0; chunk index 0.
REQ-024 in_ready is 0 during any cycle in which reset is asserted.

Structure
REQ-025 Shared package decrypt_pkg holds:
  - state enumeration;
  - default POLY and KEY_DEFAULT;
  - the seed-fold function.
REQ-026 Sub-module keystream_lfsr (parameters DATAW and POLY) owns the LFSR register and implements load, step and hold.

Verification
REQ-027 Reset, then observe idle outputs -> in_ready = 1, out_valid = 0, out_data = 0, word_cnt = 0, key_err = 0.
REQ-028 Load key 0, set ks_mode = 1, send 0x00000000 -> out_data = 0xCBFFFFFF, with out_valid on the edge 2 cycles after the handshake.
REQ-029 Load key 0, set ks_mode = 0, send 0x00000000 twice -> outputs 0xCBFFFFFF then 0xDCFFD1FF; word_cnt = 2.
REQ-030 Hold out_ready = 0 for 5 cycles and pulse key_load during DECRYPT -> out_data is stable, in_ready = 0, key_err = 1, key unchanged.
REQ-031 Assert reset mid-DECRYPT -> no out_valid is produced, and the next word decrypts as in REQ-028 under KEY_DEFAULT.
REQ-032 Preload word_cnt to 0xFFFF via delivered words, then deliver one more -> word_cnt = 0x0000.
